// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory, control and IF/ID signals.
// master: the fetch stage itself; slave: the surrounding pipeline/memory.
interface fetch_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic             stall;
    logic             flush;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             jump;
    logic [25:0]      jump_index;
    logic [31:0]      if_id_instr;
    logic [XLEN-1:0]  if_id_pc4;
    logic             if_id_valid;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  flush,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_index,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output flush,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_index,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (stall > branch >
// jump > sequential), IF/ID pipeline register with bubble insertion on
// flush/redirect, and a saturating count of accepted instructions.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_WORD = 32'h0000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
);
    localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0]  ALIGN_M  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [XLEN-1:0]  pc_r;
    logic [31:0]      if_id_instr_r;
    logic [XLEN-1:0]  if_id_pc4_r;
    logic             if_id_valid_r;
    logic [CNT_W-1:0] fetch_count_r;

    logic             stall_s;
    logic             flush_s;
    logic             branch_s;
    logic             jump_s;
    logic [XLEN-1:0]  pc4_s;
    logic [XLEN-1:0]  jump_target_s;
    logic [XLEN-1:0]  branch_target_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             bubble_s;
    logic             load_s;
    logic             count_inc_s;

    // Control inputs are forced low while reset is asserted so X on them cannot leak.
    assign stall_s  = bus.stall        & rst_n;
    assign flush_s  = bus.flush        & rst_n;
    assign branch_s = bus.branch_taken & rst_n;
    assign jump_s   = bus.jump         & rst_n;

    // Sequential PC wraps naturally; jump target uses the ID instruction's PC+4 region.
    assign pc4_s           = pc_r + PC_STEP;
    assign jump_target_s   = {if_id_pc4_r[XLEN-1:28], bus.jump_index, 2'b00};
    assign branch_target_s = bus.branch_target & ALIGN_M;

    // Next-PC selection and IF/ID update mode, fixed priority stall > branch > jump.
    always_comb begin
        next_pc_s   = pc4_s;
        bubble_s    = 1'b0;
        load_s      = 1'b0;
        count_inc_s = 1'b0;
        if (stall_s) begin
            next_pc_s = pc_r;
        end else if (branch_s) begin
            next_pc_s = branch_target_s;
        end else if (jump_s) begin
            next_pc_s = jump_target_s;
        end else begin
            next_pc_s = pc4_s;
        end
        // A redirect squashes the wrong-path fetch; flush bubbles even while stalled.
        bubble_s    = flush_s | ((branch_s | jump_s) & ~stall_s);
        load_s      = ~stall_s & ~bubble_s;
        count_inc_s = load_s & (fetch_count_r != CNT_MAX);
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // IF/ID pipeline register: bubble, load, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc4_r   <= {XLEN{1'b0}};
            if_id_valid_r <= 1'b0;
        end else if (bubble_s) begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc4_r   <= pc4_s;
            if_id_valid_r <= 1'b0;
        end else if (load_s) begin
            if_id_instr_r <= bus.imem_rdata;
            if_id_pc4_r   <= pc4_s;
            if_id_valid_r <= 1'b1;
        end else begin
            if_id_instr_r <= if_id_instr_r;
            if_id_pc4_r   <= if_id_pc4_r;
            if_id_valid_r <= if_id_valid_r;
        end
    end

    // Saturating count of instructions accepted into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= {CNT_W{1'b0}};
        end else if (count_inc_s) begin
            fetch_count_r <= fetch_count_r + CNT_ONE;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign bus.imem_addr   = pc_r;
    assign bus.if_id_instr = if_id_instr_r;
    assign bus.if_id_pc4   = if_id_pc4_r;
    assign bus.if_id_valid = if_id_valid_r;
    assign bus.fetch_count = fetch_count_r;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage with an IF/ID pipeline register for the pipelined processor.
- Holds the PC and drives the instruction-memory address.
- Computes PC+4 and forms the jump target {PC+4[top 4 bits], index, 00} internally.
- Applies stall, flush and branch/jump redirect with fixed priority, and keeps a saturating fetch counter for performance and verification.

Parameters:
- XLEN, 32: PC/address width; must be ≥ 32.
- RESET_PC, 0: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: instruction word inserted into IF/ID on a bubble.
- CNT_W, 16: fetch counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  XLEN  instruction memory address; combinational copy of the PC.
- imem_rdata  in  32  instruction word; combinational read, valid in the same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  clear IF/ID to a bubble.
- branch_taken  in  1  ID stage resolved a taken branch.
- branch_target  in  XLEN  branch target from ID (PC+4 + sext(imm)<<2).
- jump  in  1  ID stage holds a J-type jump.
- jump_index  in  26  instr[25:0] of the ID-stage jump.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  XLEN  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  CNT_W  number of instructions accepted into IF/ID; saturates.

Behaviour:
- Reset (async, while rst_n = 0):
  - pc = RESET_PC
  - if_id_instr = NOP_WORD
  - if_id_pc4 = 0
  - if_id_valid = 0
  - fetch_count = 0
- Release: the first fetch of RESET_PC happens on the first rising edge with rst_n = 1.
- pc4 = pc + 4, modulo 2^XLEN. Wrap from all-ones-minus-3 to 0 is legal and not flagged.
- jump_target = {if_id_pc4[XLEN-1:28], jump_index, 2'b00}. It is formed from the registered pc4 of the ID-stage instruction, not the current pc.
- branch_target bits [1:0] are ignored (forced to 00).
- Next-PC priority each rising edge, highest first:
  1. stall = 1: pc holds. IF/ID holds unless flush = 1. Redirects are ignored this cycle; ID re-presents them after the stall drops.
  2. branch_taken = 1: pc ← branch_target.
  3. jump = 1: pc ← jump_target. If branch_taken and jump are both 1, branch wins.
  4. Otherwise: pc ← pc4.
- IF/ID update each rising edge:
  - flush = 1 (any stall state), or redirect with stall = 0: instr ← NOP_WORD, pc4 ← pc4, valid ← 0. The wrong-path instruction is squashed, giving exactly one bubble per redirect.
  - stall = 1 and flush = 0: all IF/ID fields hold.
  - Otherwise: instr ← imem_rdata, pc4 ← pc4, valid ← 1.
- fetch_count increments by 1 on every edge where valid is loaded with 1. It holds at 2^CNT_W−1; no wrap.
- Latency: instruction at address A appears on if_id_instr one edge after imem_addr = A.
- Redirect penalty: 1 bubble cycle.
- Mid-operation reset: asserting rst_n = 0 at any point returns all state to reset values immediately, independent of clk.
- No X propagation: the stall, flush, branch_taken and jump inputs are treated as 0 during reset.

Test Plan:
- Reset release, no control asserted, imem returns addr|0xA000_0000 → imem_addr 0,4,8; if_id_instr A000_0000 then A000_0004; if_id_pc4 4 then 8; valid high from the 1st edge; fetch_count 1,2,3.
- stall held 2 cycles at pc = 0x10 → imem_addr stays 0x10, IF/ID unchanged, fetch_count frozen. Resumes with 0x14 on the next edge.
- branch_taken with target 0x40 while pc = 0x18 → next imem_addr 0x40; if_id_valid = 0 and if_id_instr = NOP for 1 cycle; then the instruction from 0x40 with pc4 0x44.
- jump with if_id_pc4 = 0x3000_0010, jump_index = 26'h0000100 → pc becomes 0x3000_0400. branch_taken+jump together with branch_target 0x80 → pc 0x80.
- stall + branch_taken together → pc holds; branch takes effect on the first non-stall cycle. stall + flush → pc holds, if_id_valid = 0.
- CNT_W = 2, run 6 fetches → fetch_count saturates at 3. rst_n pulsed low mid-run between edges → pc = RESET_PC, all outputs at reset values immediately.
